turbo_encode_rsc: RTL and testbench
===================================

Name: turbo_encode_rsc

Overview:
- Synthesizable rate-1/3 turbo encoder; the transmit-side counterpart of turbo_decode. It replaces turbo_encode_behav in benches and datapaths.
- Takes one N-bit block in parallel and runs two 4-state RSC encoders, one bit per cycle. Encoder 2 reads the block through a prime-step interleaver.
- Emits systematic and parity rows already laid out in turbo_decode's y[3][N+TAIL_BITS] ordering: row 0 systematic, row 1 parity 1, row 2 parity 2.

Parameters:
- N, 64, block length in bits.
- P, 3, interleaver step, pi(i) = (i*P) mod N. gcd(P,N) must be 1; elaboration $error otherwise.
- TAIL_BITS, 2, termination length. Must equal 2, the encoder memory; elaboration $error otherwise.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: block present on x. Accepted only when in_ready=1.
- in_ready, output, 1: high in IDLE only.
- x, input, logic x[N]: information bits. Sampled on the accept cycle.
- out_valid, output, 1: one-cycle pulse; y is complete.
- y, output, logic y[3][N+TAIL_BITS]: row 0 systematic incl. enc-1 tail inputs; row 1 enc-1 parity; row 2 enc-2 parity incl. its tail parity.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, all y bits=0, both RSC states=00, counters=0.
- RSC, RECURSIVE=7, POLY {5,7}, state {s1,s0}:
  - a = u^s1^s0; parity = a^s0; next state = {a,s1}.
  - Systematic bit = u.
- FSM:
  - IDLE: on in_valid, latch x into an internal buffer, clear i, clear addr, clear both RSC states, go to DATA.
  - DATA: each cycle, step i = 0..N-1:
    - enc-1 u=xbuf[i]; write y[0][i]=u and y[1][i]=parity1.
    - enc-2 u=xbuf[addr]; write y[2][i]=parity2.
    - addr <= (addr+P>=N) ? addr+P-N : addr+P. No multiplier.
    - After i=N-1, go to TAIL.
  - TAIL: for t = 0..TAIL_BITS-1, each encoder independently drives u=s1^s0, which forces a=0.
    - y[0][N+t]=enc-1 u; y[1][N+t]=parity1; y[2][N+t]=parity2.
    - After the last tail step both states are 00. Go to DONE.
  - DONE: out_valid=1 for this cycle only; go to IDLE.
- Latency: accept at edge k; out_valid is high during cycle k+N+TAIL_BITS+1. in_ready is low for N+TAIL_BITS+1 cycles.
- y holds its value until overwritten by the next block. Bits of a new block become visible progressively during its DATA/TAIL phases. Consumers sample y only while out_valid=1.
- in_valid while in_ready=0 is ignored, with no effect on the block in progress.
- in_valid during the DONE cycle is ignored. It is accepted from the following IDLE cycle, giving back-to-back throughput of one block per N+TAIL_BITS+2 cycles.
- Counter i width = $clog2(N+TAIL_BITS+1); addr width = $clog2(N).
- reset_n low mid-block: abort immediately and return to the reset values. No out_valid for the aborted block.

Optional Feature:
- TURBO_ENCODE_TAIL_SYS2_EN defined:
  - Adds output port y_tail2 (logic y_tail2[TAIL_BITS]), holding enc-2 tail input bits written during TAIL. Reset value 0.
  - Allows full-tail decoders.
- Undefined: port absent; enc-2 tail inputs are discarded.

Decomposition:
- Package turbo_encode_pkg holds:
  - enum enc_state_t {IDLE, DATA, TAIL, DONE};
  - typedef rsc_state_t (logic [1:0]);
  - function rsc_step(u, s) returning {next_state, parity};
  - constants RSC_MEM=2, NROWS=3.
- One sub-module, rsc4_encoder:
  - Registered state, with clear and step inputs, plus a term input that selects u=s1^s0.
  - Outputs u_used and parity.
  - Instantiated twice.

Test Plan:
- All-zero block -> every y bit 0; out_valid exactly 67 cycles after accept (N=64); in_ready returns 1 the cycle after the pulse.
- Impulse x[0]=1, rest 0:
  - y[0][0]=1, y[0][1..63]=0.
  - y[1][0..6]=1,1,1,0,1,1,0; the pattern 1,1,0 repeats from index 1.
  - y[2] identical to y[1], since pi(0)=0.
  - Both encoders end in state 00 after the tail.
- x[i] = ((i/3)%2==0) pattern, encoded at SNR-free loopback into turbo_decode (HALF_ITER=4, mapping ±1 ×2.0) -> decoded x matches, Errors()=0.
- Interleaver check, impulse x[1]=1 -> enc-2 first nonzero parity at i=43 (43*3 mod 64 = 1); y[2][0..42]=0.
- in_valid held high continuously for 3 blocks with distinct data -> exactly 3 out_valid pulses spaced 68 cycles apart; each y matches the reference model; mid-block x changes have no effect.
- reset_n pulsed low at DATA step i=20 -> y cleared, no out_valid; the next block encodes correctly. With TURBO_ENCODE_TAIL_SYS2_EN, y_tail2 equals the enc-2 termination bits from the reference model.

Source files
------------

// File: rtl/turbo_encode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_encode_pkg
// Description : Shared types, constants and the 4-state RSC step function
//               used by the turbo_encode_rsc encoder and its RSC sub-module.
//               Optional macro TURBO_ENCODE_TAIL_SYS2_EN (used by the
//               encoder and its interface, not by this package).
// Revision    : 1.0 - initial release
// ============================================================================
package turbo_encode_pkg;

    // Encoder memory (number of state bits) and number of output rows.
    localparam int RSC_MEM = 2;
    localparam int NROWS   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } enc_state_t;

    // RSC state {s1, s0}.
    typedef logic [1:0] rsc_state_t;

    // One step of the recursive (feedback 7) / parity (5) code.
    // Returns {next_state, parity}.
    function automatic logic [2:0] rsc_step(input logic u, input rsc_state_t s);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[1], a ^ s[0]};
    endfunction

    // Constant-evaluable gcd for the interleaver step check.
    function automatic int gcd_int(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

endpackage : turbo_encode_pkg
`default_nettype wire

// File: rtl/turbo_encode_rsc_if.sv
`default_nettype none
// ============================================================================
// Module      : turbo_encode_rsc_if
// Description : Block handshake and output bus of the turbo encoder.
//               master : block source / result consumer
//               slave  : the encoder
//               in_valid/in_ready/x : block input, x sampled on accept
//               out_valid/y         : one-cycle result pulse and y rows
//               y_tail2             : enc-2 tail inputs, present only when
//                                     TURBO_ENCODE_TAIL_SYS2_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface turbo_encode_rsc_if #(
    parameter int N         = 64,
    parameter int TAIL_BITS = 2
);
    import turbo_encode_pkg::*;

    logic in_valid;
    logic in_ready;
    logic x [N];
    logic out_valid;
    logic y [NROWS][N+TAIL_BITS];
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
    logic y_tail2 [TAIL_BITS];
`endif

`ifdef TURBO_ENCODE_TAIL_SYS2_EN
    modport master (output in_valid, x, input in_ready, out_valid, y, y_tail2);
    modport slave  (input in_valid, x, output in_ready, out_valid, y, y_tail2);
`else
    modport master (output in_valid, x, input in_ready, out_valid, y);
    modport slave  (input in_valid, x, output in_ready, out_valid, y);
`endif

endinterface : turbo_encode_rsc_if
`default_nettype wire

// File: rtl/turbo_encode_rsc_rsc4_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rsc4_encoder
// Description : 4-state recursive systematic convolutional encoder, one bit
//               per step. Ports:
//               clk, reset_n : clock, asynchronous active-low reset
//               clear        : force state to 00 (wins over step)
//               step         : advance state using u_used
//               term         : use u = s1^s0 (drives feedback to 0)
//               u            : information bit when term=0
//               u_used       : bit actually fed to the encoder
//               parity       : parity bit for the current step
// Revision    : 1.0 - initial release
// ============================================================================
module rsc4_encoder
    import turbo_encode_pkg::*;
(
    input  wire  clk,
    input  wire  reset_n,
    input  wire  clear,
    input  wire  step,
    input  wire  term,
    input  wire  u,
    output logic u_used,
    output logic parity
);

    rsc_state_t state_q;
    rsc_state_t state_d;
    logic [2:0] w_step_res;

    always_comb begin
        u_used     = term ? (state_q[1] ^ state_q[0]) : u;
        w_step_res = rsc_step(u_used, state_q);
        parity     = w_step_res[0];
        state_d    = state_q;
        if (clear) begin
            state_d = '0;
        end else if (step) begin
            state_d = w_step_res[2:1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : rsc4_encoder
`default_nettype wire

// File: rtl/turbo_encode_rsc.sv
`default_nettype none
// ============================================================================
// Module      : turbo_encode_rsc
// Description : Rate-1/3 turbo encoder. Accepts an N-bit block in parallel,
//               runs two 4-state RSC encoders one bit per cycle (encoder 2
//               through the prime-step interleaver pi(i) = i*P mod N), then
//               terminates both and pulses out_valid with y laid out as
//               row 0 systematic, row 1 parity 1, row 2 parity 2.
//               Ports: clk, reset_n (async active-low), bus (slave modport
//               of turbo_encode_rsc_if).
//               Optional macro TURBO_ENCODE_TAIL_SYS2_EN adds y_tail2, the
//               encoder-2 termination input bits.
// Revision    : 1.0 - initial release
// ============================================================================
module turbo_encode_rsc
    import turbo_encode_pkg::*;
#(
    parameter int N         = 64,
    parameter int P         = 3,
    parameter int TAIL_BITS = 2
) (
    input  wire              clk,
    input  wire              reset_n,
    turbo_encode_rsc_if.slave bus
);

    localparam int c_W     = N + TAIL_BITS;
    localparam int c_IW    = $clog2(N + TAIL_BITS + 1);
    localparam int c_AW    = $clog2(N);
    localparam int c_YW    = $clog2(c_W);
    localparam int c_P_MOD = P % N;

    if (gcd_int(P, N) != 1) begin : g_bad_step
        $error("turbo_encode_rsc: gcd(P, N) must be 1");
    end
    if (TAIL_BITS != RSC_MEM) begin : g_bad_tail
        $error("turbo_encode_rsc: TAIL_BITS must equal the encoder memory");
    end

    enc_state_t      state_q,     state_d;
    logic [N-1:0]    xbuf_q,      xbuf_d;
    logic [c_IW-1:0] i_q,         i_d;
    logic [c_AW-1:0] addr_q,      addr_d;
    logic [c_W-1:0]  y_q [NROWS];
    logic [c_W-1:0]  y_d [NROWS];
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
    logic [TAIL_BITS-1:0] y_tail2_q, y_tail2_d;
`endif

    logic            w_clear;
    logic            w_step;
    logic            w_term;
    logic            w_u1_used, w_p1;
    logic            w_u2_used, w_p2;
    logic [c_AW:0]   w_addr_sum;
    logic [c_YW-1:0] w_col;

    rsc4_encoder u_enc1 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .step    (w_step),
        .term    (w_term),
        .u       (xbuf_q[i_q[c_AW-1:0]]),
        .u_used  (w_u1_used),
        .parity  (w_p1)
    );

    rsc4_encoder u_enc2 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .step    (w_step),
        .term    (w_term),
        .u       (xbuf_q[addr_q]),
        .u_used  (w_u2_used),
        .parity  (w_p2)
    );

    // Interleaver address walks by P modulo N with a single conditional
    // subtract, so pi(i) never needs a multiplier.
    assign w_addr_sum = {1'b0, addr_q} + (c_AW+1)'(c_P_MOD);
    assign w_col      = i_q[c_YW-1:0];

    always_comb begin
        state_d     = state_q;
        xbuf_d      = xbuf_q;
        i_d         = i_q;
        addr_d      = addr_q;
        y_d         = y_q;
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
        y_tail2_d   = y_tail2_q;
`endif
        w_clear     = 1'b0;
        w_step      = 1'b0;
        w_term      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        xbuf_d[k] = bus.x[k];
                    end
                    i_d     = '0;
                    addr_d  = '0;
                    w_clear = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                w_step          = 1'b1;
                y_d[0][w_col]   = w_u1_used;
                y_d[1][w_col]   = w_p1;
                y_d[2][w_col]   = w_p2;
                addr_d = (w_addr_sum >= (c_AW+1)'(N))
                       ? c_AW'(w_addr_sum - (c_AW+1)'(N))
                       : w_addr_sum[c_AW-1:0];
                i_d = i_q + 1'b1;
                if (i_q == c_IW'(N - 1)) begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                // i keeps counting past N so tail bits land in columns N..
                w_step          = 1'b1;
                w_term          = 1'b1;
                y_d[0][w_col]   = w_u1_used;
                y_d[1][w_col]   = w_p1;
                y_d[2][w_col]   = w_p2;
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
                for (int t = 0; t < TAIL_BITS; t++) begin
                    if (i_q == c_IW'(N + t)) begin
                        y_tail2_d[t] = w_u2_used;
                    end
                end
`endif
                i_d = i_q + 1'b1;
                if (i_q == c_IW'(N + TAIL_BITS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            xbuf_q      <= '0;
            i_q         <= '0;
            addr_q      <= '0;
            for (int r = 0; r < NROWS; r++) begin
                y_q[r] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
            y_tail2_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            xbuf_q      <= xbuf_d;
            i_q         <= i_d;
            addr_q      <= addr_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
            y_tail2_q   <= y_tail2_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        for (genvar c = 0; c < c_W; c++) begin : g_col
            assign bus.y[r][c] = y_q[r][c];
        end
    end

`ifdef TURBO_ENCODE_TAIL_SYS2_EN
    for (genvar t = 0; t < TAIL_BITS; t++) begin : g_tail2
        assign bus.y_tail2[t] = y_tail2_q[t];
    end
`endif

endmodule : turbo_encode_rsc
`default_nettype wire

// File: tb/tb_turbo_encode_rsc.sv
`default_nettype none
// ============================================================================
// Module      : tb_turbo_encode_rsc
// Description : Self-checking bench for turbo_encode_rsc. Table of block
//               vectors with expected rows, plus back-to-back, mid-block
//               reset and interleaver corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_turbo_encode_rsc;

    localparam int N  = 64;
    localparam int P  = 3;
    localparam int TB = 2;
    localparam int W  = N + TB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    turbo_encode_rsc_if #(.N(N), .TAIL_BITS(TB)) bus_if ();

    turbo_encode_rsc #(.N(N), .P(P), .TAIL_BITS(TB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string          name;
        logic [N-1:0]   x;
        logic [W-1:0]   e0;
        logic [W-1:0]   e1;
        logic [W-1:0]   e2;
        logic [TB-1:0]  et2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] get_row(input int r);
        logic [W-1:0] v;
        for (int c = 0; c < W; c++) v[c] = bus_if.y[r][c];
        return v;
    endfunction

    task automatic set_x(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) bus_if.x[k] = v[k];
    endtask

    function automatic logic [N-1:0] rand_block();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Reference: feed a bit sequence through the RSC rules, then terminate
    // with u = s1^s0 for TB steps.
    function automatic void rsc_run(input logic [N-1:0] seq,
                                    output logic [W-1:0] sys, output logic [W-1:0] par);
        int s1 = 0, s0 = 0, u, a;
        for (int t = 0; t < W; t++) begin
            u = (t < N) ? int'(seq[t]) : (s1 ^ s0);
            a = u ^ s1 ^ s0;
            sys[t] = u[0];
            par[t] = 1'(a ^ s0);
            s0 = s1;
            s1 = a;
        end
    endfunction

    function automatic void ref_encode(input logic [N-1:0] xv,
                                       output logic [W-1:0] r0, output logic [W-1:0] r1,
                                       output logic [W-1:0] r2, output logic [TB-1:0] t2);
        logic [N-1:0] xi;
        logic [W-1:0] sys2;
        for (int i = 0; i < N; i++) xi[i] = xv[(i * P) % N];
        rsc_run(xv, r0, r1);
        rsc_run(xi, sys2, r2);
        t2 = sys2[W-1:N];
    endfunction

    // Apply one block, then compare latency, busy time, rows and the
    // return to IDLE.
    task automatic run_block(input string nm, input logic [N-1:0] xv,
                             input logic [W-1:0] e0, input logic [W-1:0] e1,
                             input logic [W-1:0] e2, input logic [TB-1:0] et2);
        int lat, low, wt;
        bit seen;
        wt = 0;
        while (!bus_if.in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        bus_if.in_valid = 1'b1;
        set_x(xv);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        set_x(rand_block());
        lat = 1; low = 0; seen = 0;
        while (lat < 200) begin
            if (!bus_if.in_ready) low++;
            if (bus_if.out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({nm, " out_valid seen"}, W'(seen), W'(1));
        check({nm, " latency"}, W'(lat), W'(N + TB + 1));
        check({nm, " in_ready low cycles"}, W'(low), W'(N + TB + 1));
        check({nm, " y0"}, get_row(0), e0);
        check({nm, " y1"}, get_row(1), e1);
        check({nm, " y2"}, get_row(2), e2);
`ifdef TURBO_ENCODE_TAIL_SYS2_EN
        begin
            logic [TB-1:0] t2;
            for (int t = 0; t < TB; t++) t2[t] = bus_if.y_tail2[t];
            check({nm, " y_tail2"}, W'(t2), W'(et2));
        end
`else
        if (et2 === 'x) $display("unused");
`endif
        @(negedge clk);
        check({nm, " out_valid pulse width"}, W'(bus_if.out_valid), W'(0));
        check({nm, " in_ready after pulse"}, W'(bus_if.in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2;
        logic [TB-1:0] t2;
        logic [N-1:0] xv;
        int first;
        int pulses [3];
        int npulse, nacc, ones;

        bus_if.in_valid = 1'b0;
        set_x('0);

        // ---- vector table ----
        vecs[0].name = "zero";
        vecs[0].x = '0; vecs[0].e0 = '0; vecs[0].e1 = '0; vecs[0].e2 = '0; vecs[0].et2 = '0;

        // Impulse at 0: parity 1 then 1,1,0 repeating; end state 10 gives
        // tail inputs 1,1 with parities 0,1. pi(0)=0 so encoder 2 matches.
        vecs[1].name = "impulse0";
        vecs[1].x = '0; vecs[1].x[0] = 1'b1;
        vecs[1].e0 = '0; vecs[1].e0[0] = 1'b1; vecs[1].e0[N] = 1'b1; vecs[1].e0[N+1] = 1'b1;
        vecs[1].e1 = '0; vecs[1].e1[0] = 1'b1;
        for (int i = 1; i < N; i++) vecs[1].e1[i] = (((i - 1) % 3) != 2);
        vecs[1].e1[N] = 1'b0; vecs[1].e1[N+1] = 1'b1;
        vecs[1].e2 = vecs[1].e1;
        vecs[1].et2 = 2'b11;

        vecs[2].name = "impulse1";
        xv = '0; xv[1] = 1'b1;
        vecs[2].x = xv;
        vecs[3].name = "pattern3";
        for (int i = 0; i < N; i++) xv[i] = (((i / 3) % 2) == 0);
        vecs[3].x = xv;
        vecs[4].name = "random_a"; vecs[4].x = rand_block();
        vecs[5].name = "random_b"; vecs[5].x = rand_block();
        for (int v = 2; v < 6; v++) begin
            ref_encode(vecs[v].x, r0, r1, r2, t2);
            vecs[v].e0 = r0; vecs[v].e1 = r1; vecs[v].e2 = r2; vecs[v].et2 = t2;
        end

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset in_ready", W'(bus_if.in_ready), W'(1));
        check("reset out_valid", W'(bus_if.out_valid), W'(0));
        check("reset y0", get_row(0), '0);
        check("reset y1", get_row(1), '0);
        check("reset y2", get_row(2), '0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].name, vecs[v].x, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].et2);
            check({vecs[v].name, " enc1 end state"}, W'(dut.u_enc1.state_q), W'(0));
            check({vecs[v].name, " enc2 end state"}, W'(dut.u_enc2.state_q), W'(0));
            if (v == 2) begin
                // y2 still holds impulse1 here; 43*3 mod 64 = 1.
                first = -1;
                for (int i = W - 1; i >= 0; i--) if (bus_if.y[2][i]) first = i;
                check("impulse1 first enc2 parity", W'(first), W'(43));
            end
        end

        // ---- back-to-back, in_valid held high ----
        begin
            logic [N-1:0] blk [3];
            for (int b = 0; b < 3; b++) blk[b] = rand_block();
            npulse = 0; nacc = 0;
            bus_if.in_valid = 1'b1;
            for (int cyc = 0; cyc < 400 && npulse < 3; cyc++) begin
                if (bus_if.out_valid) begin
                    ref_encode(blk[npulse], r0, r1, r2, t2);
                    check("b2b y0", get_row(0), r0);
                    check("b2b y1", get_row(1), r1);
                    check("b2b y2", get_row(2), r2);
                    pulses[npulse] = cyc;
                    npulse++;
                end
                if (bus_if.in_ready && nacc < 3) begin
                    set_x(blk[nacc]);
                    nacc++;
                end else begin
                    set_x(rand_block());
                    if (nacc >= 3) bus_if.in_valid = 1'b0;
                end
                @(negedge clk);
            end
            bus_if.in_valid = 1'b0;
            check("b2b pulse count", W'(npulse), W'(3));
            if (npulse == 3) begin
                check("b2b spacing 1", W'(pulses[1] - pulses[0]), W'(N + TB + 2));
                check("b2b spacing 2", W'(pulses[2] - pulses[1]), W'(N + TB + 2));
            end
        end

        // ---- reset mid-block at DATA step 20 ----
        repeat (2) @(negedge clk);
        bus_if.in_valid = 1'b1;
        set_x(rand_block());
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort y0 cleared", get_row(0), '0);
        check("abort y1 cleared", get_row(1), '0);
        check("abort y2 cleared", get_row(2), '0);
        check("abort in_ready", W'(bus_if.in_ready), W'(1));
        @(negedge clk);
        reset_n = 1'b1;
        ones = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_if.out_valid) ones++;
        end
        check("abort no out_valid", W'(ones), W'(0));
        xv = rand_block();
        ref_encode(xv, r0, r1, r2, t2);
        run_block("after_abort", xv, r0, r1, r2, t2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_turbo_encode_rsc
`default_nettype wire
